axi_read_arbiter: RTL

- Shares one AXI read channel (AR/R) between two cache-side requesters: instruction side (requester 0, L1I refill) and data side (requester 1, L1D refill/uncached load).
- Sits between the instruction/data Master read ports and the single downstream read port, so one outstanding read burst reaches the interconnect at a time.
- Uses round-robin arbitration and holds the grant for the whole burst.
- Checks beat count and RID against the accepted request, and reports violations on a sticky error output.

---
 rtl/axi_read_arbiter.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_read_arbiter.sv
// Two-requester AXI read-channel arbiter.
// Requester 0 is the instruction side and requester 1 is the data side.
// Only one read burst is outstanding downstream at any time.
// A round-robin grant is held for the whole burst.
// The R stream is checked for beat count and RID, and violations set sticky error bits.
module axi_read_arbiter #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    // requester 0 (instruction side)
    input  logic [ID_W-1:0]   ARID_R0,
    input  logic [ADDR_W-1:0] ARADDR_R0,
    input  logic [LEN_W-1:0]  ARLEN_R0,
    input  logic [2:0]        ARSIZE_R0,
    input  logic [1:0]        ARBURST_R0,
    input  logic              ARVALID_R0,
    output logic              ARREADY_R0,
    output logic [ID_W-1:0]   RID_R0,
    output logic [DATA_W-1:0] RDATA_R0,
    output logic [1:0]        RRESP_R0,
    output logic              RLAST_R0,
    output logic              RVALID_R0,
    input  logic              RREADY_R0,
    // requester 1 (data side)
    input  logic [ID_W-1:0]   ARID_R1,
    input  logic [ADDR_W-1:0] ARADDR_R1,
    input  logic [LEN_W-1:0]  ARLEN_R1,
    input  logic [2:0]        ARSIZE_R1,
    input  logic [1:0]        ARBURST_R1,
    input  logic              ARVALID_R1,
    output logic              ARREADY_R1,
    output logic [ID_W-1:0]   RID_R1,
    output logic [DATA_W-1:0] RDATA_R1,
    output logic [1:0]        RRESP_R1,
    output logic              RLAST_R1,
    output logic              RVALID_R1,
    input  logic              RREADY_R1,
    // downstream read port
    output logic [ID_W-1:0]   ARID_S,
    output logic [ADDR_W-1:0] ARADDR_S,
    output logic [LEN_W-1:0]  ARLEN_S,
    output logic [2:0]        ARSIZE_S,
    output logic [1:0]        ARBURST_S,
    output logic              ARVALID_S,
    input  logic              ARREADY_S,
    input  logic [ID_W-1:0]   RID_S,
    input  logic [DATA_W-1:0] RDATA_S,
    input  logic [1:0]        RRESP_S,
    input  logic              RLAST_S,
    input  logic              RVALID_S,
    output logic              RREADY_S,
    // status
    output logic              busy,
    output logic [1:0]        err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_AR_SEND = 2'd1,
        ST_R_DATA  = 2'd2
    } state_e;

    // The beat count is wrong if RLAST comes on any beat other than beat ARLEN.
    // It is also wrong if beat ARLEN arrives without RLAST.
    function automatic logic beat_count_error(
        input logic             last,
        input logic [LEN_W:0]   cnt,
        input logic [LEN_W-1:0] len
    );
        logic at_len;
        at_len = (cnt == {1'b0, len});
        beat_count_error = last ? !at_len : at_len;
    endfunction

    state_e              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                grant_q, grant_d;
    logic [LEN_W:0]      beat_cnt_q, beat_cnt_d;
    logic [1:0]          err_q, err_d;
    logic [ID_W-1:0]     ar_id_q, ar_id_d;
    logic [ADDR_W-1:0]   ar_addr_q, ar_addr_d;
    logic [LEN_W-1:0]    ar_len_q, ar_len_d;
    logic [2:0]          ar_size_q, ar_size_d;
    logic [1:0]          ar_burst_q, ar_burst_d;

    logic                grant_sel_s;
    logic                ar_hs_s;
    logic                r_route_s;
    logic                beat_s;

    // Choose the requester to grant in IDLE. On a tie, the requester that was not served last wins.
    always_comb begin
        grant_sel_s = 1'b0;
        ar_hs_s     = 1'b0;
        if (state_q == ST_IDLE) begin
            ar_hs_s = ARVALID_R0 | ARVALID_R1;
            if (ARVALID_R0 && ARVALID_R1) begin
                grant_sel_s = ~last_grant_q;
            end else if (ARVALID_R1) begin
                grant_sel_s = 1'b1;
            end else begin
                grant_sel_s = 1'b0;
            end
        end else begin
            grant_sel_s = 1'b0;
            ar_hs_s     = 1'b0;
        end
    end

    // Drive the AR ready back to the selected requester in the same cycle. Other requests are held off.
    always_comb begin
        ARREADY_R0 = ar_hs_s & ~grant_sel_s;
        ARREADY_R1 = ar_hs_s &  grant_sel_s;
    end

    // Route the downstream R channel to the granted requester. The other requester sees zeros.
    always_comb begin
        r_route_s = (state_q == ST_R_DATA);
        RVALID_R0 = 1'b0;
        RID_R0    = {ID_W{1'b0}};
        RDATA_R0  = {DATA_W{1'b0}};
        RRESP_R0  = 2'b00;
        RLAST_R0  = 1'b0;
        RVALID_R1 = 1'b0;
        RID_R1    = {ID_W{1'b0}};
        RDATA_R1  = {DATA_W{1'b0}};
        RRESP_R1  = 2'b00;
        RLAST_R1  = 1'b0;
        RREADY_S  = 1'b0;
        if (r_route_s) begin
            if (grant_q) begin
                RVALID_R1 = RVALID_S;
                RID_R1    = RID_S;
                RDATA_R1  = RDATA_S;
                RRESP_R1  = RRESP_S;
                RLAST_R1  = RLAST_S;
                RREADY_S  = RREADY_R1;
            end else begin
                RVALID_R0 = RVALID_S;
                RID_R0    = RID_S;
                RDATA_R0  = RDATA_S;
                RRESP_R0  = RRESP_S;
                RLAST_R0  = RLAST_S;
                RREADY_S  = RREADY_R0;
            end
        end else begin
            RREADY_S = 1'b0;
        end
        beat_s = r_route_s & RVALID_S & RREADY_S;
    end

    // Compute the next state: capture the request, send it downstream, then track and check its beats.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        beat_cnt_d   = beat_cnt_q;
        err_d        = err_q;
        ar_id_d      = ar_id_q;
        ar_addr_d    = ar_addr_q;
        ar_len_d     = ar_len_q;
        ar_size_d    = ar_size_q;
        ar_burst_d   = ar_burst_q;
        case (state_q)
            ST_IDLE: begin
                if (ar_hs_s) begin
                    grant_d = grant_sel_s;
                    state_d = ST_AR_SEND;
                    if (grant_sel_s) begin
                        ar_id_d    = ARID_R1;
                        ar_addr_d  = ARADDR_R1;
                        ar_len_d   = ARLEN_R1;
                        ar_size_d  = ARSIZE_R1;
                        ar_burst_d = ARBURST_R1;
                    end else begin
                        ar_id_d    = ARID_R0;
                        ar_addr_d  = ARADDR_R0;
                        ar_len_d   = ARLEN_R0;
                        ar_size_d  = ARSIZE_R0;
                        ar_burst_d = ARBURST_R0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_AR_SEND: begin
                if (ARREADY_S) begin
                    beat_cnt_d = {(LEN_W+1){1'b0}};
                    state_d    = ST_R_DATA;
                end else begin
                    state_d = ST_AR_SEND;
                end
            end
            ST_R_DATA: begin
                if (beat_s) begin
                    // The counter saturates so that a runaway burst cannot alias back to a legal count.
                    if (beat_cnt_q != {(LEN_W+1){1'b1}}) begin
                        beat_cnt_d = beat_cnt_q + {{LEN_W{1'b0}}, 1'b1};
                    end else begin
                        beat_cnt_d = beat_cnt_q;
                    end
                    if (RID_S != ar_id_q) begin
                        err_d[1] = 1'b1;
                    end else begin
                        err_d[1] = err_q[1];
                    end
                    if (beat_count_error(RLAST_S, beat_cnt_q, ar_len_q)) begin
                        err_d[0] = 1'b1;
                    end else begin
                        err_d[0] = err_q[0];
                    end
                    if (RLAST_S) begin
                        last_grant_d = grant_q;
                        state_d      = ST_IDLE;
                    end else begin
                        state_d = ST_R_DATA;
                    end
                end else begin
                    state_d = ST_R_DATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and capture registers, with a synchronous reset to the documented values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            beat_cnt_q   <= {(LEN_W+1){1'b0}};
            err_q        <= 2'b00;
            ar_id_q      <= {ID_W{1'b0}};
            ar_addr_q    <= {ADDR_W{1'b0}};
            ar_len_q     <= {LEN_W{1'b0}};
            ar_size_q    <= 3'b000;
            ar_burst_q   <= 2'b00;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            beat_cnt_q   <= beat_cnt_d;
            err_q        <= err_d;
            ar_id_q      <= ar_id_d;
            ar_addr_q    <= ar_addr_d;
            ar_len_q     <= ar_len_d;
            ar_size_q    <= ar_size_d;
            ar_burst_q   <= ar_burst_d;
        end
    end

    // The downstream AR fields come straight from the capture registers, so they stay stable until accepted.
    always_comb begin
        ARVALID_S = (state_q == ST_AR_SEND);
        ARID_S    = ar_id_q;
        ARADDR_S  = ar_addr_q;
        ARLEN_S   = ar_len_q;
        ARSIZE_S  = ar_size_q;
        ARBURST_S = ar_burst_q;
        busy      = (state_q != ST_IDLE);
        err       = err_q;
    end

endmodule
